// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - collapsing-queue reservation station with CDB wakeup
// Oldest-ready issue over a valid/ready handshake; entries shift down on issue.
module reservation_station #(
    parameter int RS_SIZE   = 4,
    parameter int REG_SIZE  = 64,
    parameter int TAG_WIDTH = 5,
    parameter int OP_WIDTH  = 6,
    parameter int NUM_CDB   = 2,
    parameter int CNT_W     = $clog2(RS_SIZE + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_flush,
    input  logic                          i_dispatch_valid,
    output logic                          o_dispatch_ready,
    input  logic [OP_WIDTH-1:0]           i_dispatch_opcode,
    input  logic [TAG_WIDTH-1:0]          i_dispatch_dst_tag,
    input  logic                          i_dispatch_op1_valid,
    input  logic                          i_dispatch_op2_valid,
    input  logic [TAG_WIDTH-1:0]          i_dispatch_op1_tag,
    input  logic [TAG_WIDTH-1:0]          i_dispatch_op2_tag,
    input  logic [REG_SIZE-1:0]           i_dispatch_op1_value,
    input  logic [REG_SIZE-1:0]           i_dispatch_op2_value,
    input  logic [NUM_CDB-1:0]            i_cdb_valid,
    input  logic [NUM_CDB*TAG_WIDTH-1:0]  i_cdb_tag,
    input  logic [NUM_CDB*REG_SIZE-1:0]   i_cdb_value,
    output logic                          o_issue_valid,
    input  logic                          i_issue_ready,
    output logic [OP_WIDTH-1:0]           o_issue_opcode,
    output logic [TAG_WIDTH-1:0]          o_issue_dst_tag,
    output logic [REG_SIZE-1:0]           o_issue_op1_value,
    output logic [REG_SIZE-1:0]           o_issue_op2_value,
    output logic [CNT_W-1:0]              o_count,
    output logic [RS_SIZE-1:0]            o_debug_busy
);

    localparam int IDX_W = $clog2(RS_SIZE);

    typedef struct packed {
        logic [OP_WIDTH-1:0]  opcode;
        logic [TAG_WIDTH-1:0] dst;
        logic                 v1;
        logic [TAG_WIDTH-1:0] t1;
        logic [REG_SIZE-1:0]  x1;
        logic                 v2;
        logic [TAG_WIDTH-1:0] t2;
        logic [REG_SIZE-1:0]  x2;
    } entry_t;

    entry_t              slot_q [RS_SIZE];
    entry_t              slot_d [RS_SIZE];
    entry_t              ext    [RS_SIZE+1];
    entry_t              disp_w;
    entry_t              src;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    wr_idx;
    logic [RS_SIZE-1:0]  ready, shift;
    logic [IDX_W-1:0]    sel;
    logic                any_ready;
    logic                issue_fire, dispatch_fire;

    // Ascending channel scan with an early valid set makes the lowest channel win.
    function automatic entry_t wake(input entry_t e,
                                    input logic [NUM_CDB-1:0] cv,
                                    input logic [NUM_CDB*TAG_WIDTH-1:0] ct,
                                    input logic [NUM_CDB*REG_SIZE-1:0] cx);
        entry_t r;
        r = e;
        for (int c = 0; c < NUM_CDB; c++) begin
            if (!r.v1 && cv[c] && (ct[c*TAG_WIDTH +: TAG_WIDTH] == r.t1)) begin
                r.v1 = 1'b1;
                r.x1 = cx[c*REG_SIZE +: REG_SIZE];
            end
            if (!r.v2 && cv[c] && (ct[c*TAG_WIDTH +: TAG_WIDTH] == r.t2)) begin
                r.v2 = 1'b1;
                r.x2 = cx[c*REG_SIZE +: REG_SIZE];
            end
        end
        return r;
    endfunction

    always_comb begin
        ready        = '0;
        shift        = '0;
        sel          = '0;
        any_ready    = 1'b0;
        o_debug_busy = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            o_debug_busy[i] = (CNT_W'(i) < count_q);
            ready[i]        = o_debug_busy[i] && slot_q[i].v1 && slot_q[i].v2;
            if (ready[i] && !any_ready) begin
                sel       = IDX_W'(i);
                any_ready = 1'b1;
            end
            // Every slot at or above the selected one moves down if the issue fires.
            shift[i] = any_ready;
        end
    end

    assign o_issue_valid     = any_ready & ~i_flush;
    assign issue_fire        = o_issue_valid & i_issue_ready;
    assign o_dispatch_ready  = (count_q < CNT_W'(RS_SIZE));
    assign dispatch_fire     = i_dispatch_valid & o_dispatch_ready & ~i_flush;
    assign wr_idx            = count_q - CNT_W'(issue_fire);
    assign o_count           = count_q;
    assign o_issue_opcode    = o_issue_valid ? slot_q[sel].opcode : '0;
    assign o_issue_dst_tag   = o_issue_valid ? slot_q[sel].dst    : '0;
    assign o_issue_op1_value = o_issue_valid ? slot_q[sel].x1     : '0;
    assign o_issue_op2_value = o_issue_valid ? slot_q[sel].x2     : '0;

    always_comb begin
        disp_w        = '0;
        disp_w.opcode = i_dispatch_opcode;
        disp_w.dst    = i_dispatch_dst_tag;
        disp_w.v1     = i_dispatch_op1_valid;
        disp_w.t1     = i_dispatch_op1_tag;
        disp_w.x1     = i_dispatch_op1_value;
        disp_w.v2     = i_dispatch_op2_valid;
        disp_w.t2     = i_dispatch_op2_tag;
        disp_w.x2     = i_dispatch_op2_value;
        disp_w        = wake(disp_w, i_cdb_valid, i_cdb_tag, i_cdb_value);

        for (int i = 0; i < RS_SIZE; i++) begin
            ext[i] = slot_q[i];
        end
        ext[RS_SIZE] = '0;

        src = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            src       = (issue_fire && shift[i]) ? ext[i+1] : ext[i];
            slot_d[i] = wake(src, i_cdb_valid, i_cdb_tag, i_cdb_value);
            if (dispatch_fire && (CNT_W'(i) == wr_idx)) begin
                slot_d[i] = disp_w;
            end
        end

        count_d = i_flush ? '0 : (count_q + CNT_W'(dispatch_fire) - CNT_W'(issue_fire));
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < RS_SIZE; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - queue-model bench for reservation_station
module tb_reservation_station;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush;
    logic          d_valid;
    logic [5:0]    d_op;
    logic [4:0]    d_dst, d_t1, d_t2;
    logic          d_v1, d_v2;
    logic [63:0]   d_x1, d_x2;
    logic [1:0]    cdb_v;
    logic [9:0]    cdb_t;
    logic [127:0]  cdb_x;
    logic          iss_rdy;
    logic          o_dispatch_ready, o_issue_valid;
    logic [5:0]    o_issue_opcode;
    logic [4:0]    o_issue_dst_tag;
    logic [63:0]   o_issue_op1_value, o_issue_op2_value;
    logic [2:0]    o_count;
    logic [3:0]    o_debug_busy;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    reservation_station dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush),
        .i_dispatch_valid(d_valid), .o_dispatch_ready(o_dispatch_ready),
        .i_dispatch_opcode(d_op), .i_dispatch_dst_tag(d_dst),
        .i_dispatch_op1_valid(d_v1), .i_dispatch_op2_valid(d_v2),
        .i_dispatch_op1_tag(d_t1), .i_dispatch_op2_tag(d_t2),
        .i_dispatch_op1_value(d_x1), .i_dispatch_op2_value(d_x2),
        .i_cdb_valid(cdb_v), .i_cdb_tag(cdb_t), .i_cdb_value(cdb_x),
        .o_issue_valid(o_issue_valid), .i_issue_ready(iss_rdy),
        .o_issue_opcode(o_issue_opcode), .o_issue_dst_tag(o_issue_dst_tag),
        .o_issue_op1_value(o_issue_op1_value), .o_issue_op2_value(o_issue_op2_value),
        .o_count(o_count), .o_debug_busy(o_debug_busy)
    );

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  dst;
        bit          v1;
        logic [4:0]  t1;
        logic [63:0] x1;
        bit          v2;
        logic [4:0]  t2;
        logic [63:0] x2;
    } ent_t;

    ent_t mq[$];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Lowest-numbered channel carrying the operand's tag supplies the value.
    function automatic ent_t wake_m(ent_t e);
        int m1 = -1;
        int m2 = -1;
        for (int c = 1; c >= 0; c--) begin
            if (cdb_v[c] && cdb_t[c*5 +: 5] == e.t1) m1 = c;
            if (cdb_v[c] && cdb_t[c*5 +: 5] == e.t2) m2 = c;
        end
        if (!e.v1 && m1 >= 0) begin e.v1 = 1'b1; e.x1 = cdb_x[m1*64 +: 64]; end
        if (!e.v2 && m2 >= 0) begin e.v2 = 1'b1; e.x2 = cdb_x[m2*64 +: 64]; end
        return e;
    endfunction

    function automatic int first_ready();
        foreach (mq[j]) if (mq[j].v1 && mq[j].v2) return j;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : mdl
        int   k;
        bit   dok;
        ent_t e;
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            k   = first_ready();
            dok = d_valid && (mq.size() < 4);
            if (k >= 0 && iss_rdy) mq.delete(k);
            foreach (mq[j]) mq[j] = wake_m(mq[j]);
            if (dok) begin
                e = '{d_op, d_dst, d_v1, d_t1, d_x1, d_v2, d_t2, d_x2};
                mq.push_back(wake_m(e));
            end
        end
    end

    always @(negedge clk) begin : cmp
        int k;
        bit iv;
        if (chk_en) begin
            k  = first_ready();
            iv = (k >= 0) && !flush;
            chk("m_count", o_count, mq.size());
            chk("m_busy", o_debug_busy, (1 << mq.size()) - 1);
            chk("m_disp_ready", o_dispatch_ready, mq.size() < 4);
            chk("m_issue_valid", o_issue_valid, iv);
            chk("m_opcode", o_issue_opcode, iv ? mq[k].op : 6'd0);
            chk("m_dst", o_issue_dst_tag, iv ? mq[k].dst : 5'd0);
            chk("m_op1", o_issue_op1_value, iv ? mq[k].x1 : 64'd0);
            chk("m_op2", o_issue_op2_value, iv ? mq[k].x2 : 64'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_valid = 1'b0;
        cdb_v   = '0;
        flush   = 1'b0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [4:0] dst,
                        input bit v1, input logic [4:0] t1, input logic [63:0] x1,
                        input bit v2, input logic [4:0] t2, input logic [63:0] x2);
        d_valid = 1'b1; d_op = op; d_dst = dst;
        d_v1 = v1; d_t1 = t1; d_x1 = x1;
        d_v2 = v2; d_t2 = t2; d_x2 = x2;
    endtask

    task automatic cdb(input int ch, input logic [4:0] tag, input logic [63:0] val);
        cdb_v[ch]         = 1'b1;
        cdb_t[ch*5 +: 5]  = tag;
        cdb_x[ch*64 +: 64] = val;
    endtask

    initial begin
        idle();
        d_op = '0; d_dst = '0; d_v1 = 0; d_v2 = 0; d_t1 = '0; d_t2 = '0;
        d_x1 = '0; d_x2 = '0; cdb_t = '0; cdb_x = '0; iss_rdy = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_count", o_count, 0);
        chk("rst_ready", o_dispatch_ready, 1);
        chk("rst_valid", o_issue_valid, 0);
        chk("rst_busy", o_debug_busy, 0);

        // single fully valid dispatch issues one cycle later
        disp(1, 3, 1, 0, 5, 1, 0, 7); iss_rdy = 1'b1; cyc(); idle(); #1;
        chk("a_valid", o_issue_valid, 1);
        chk("a_op1", o_issue_op1_value, 5);
        chk("a_op2", o_issue_op2_value, 7);
        chk("a_dst", o_issue_dst_tag, 3);
        chk("a_count1", o_count, 1);
        cyc();
        chk("a_count0", o_count, 0);

        // younger ready entry overtakes an older waiting one
        iss_rdy = 1'b0;
        disp(2, 10, 0, 9, 0, 1, 0, 1); cyc();
        disp(3, 11, 1, 0, 100, 1, 0, 200); cyc(); idle(); iss_rdy = 1'b1; #1;
        chk("b_first_dst", o_issue_dst_tag, 11);
        chk("b_count", o_count, 2);
        cyc(); cdb(0, 9, 64'h2A); #1;
        chk("b_wait_valid", o_issue_valid, 0);
        cyc(); idle(); #1;
        chk("b_second_dst", o_issue_dst_tag, 10);
        chk("b_op1", o_issue_op1_value, 64'h2A);
        cyc();

        // two channels same tag; tag 0 matched exactly
        iss_rdy = 1'b0;
        disp(4, 12, 0, 4, 0, 0, 0, 0); cyc(); idle();
        cdb(0, 4, 11); cdb(1, 4, 22); cyc(); idle();
        cdb(1, 16, 55); #1;
        chk("c_tag16_nomatch", o_issue_valid, 0);
        cyc(); idle(); cdb(0, 0, 33); cyc(); idle(); #1;
        chk("c_valid", o_issue_valid, 1);
        chk("c_lowest_ch", o_issue_op1_value, 11);
        chk("c_tag0", o_issue_op2_value, 33);
        iss_rdy = 1'b1; cyc(); iss_rdy = 1'b0;

        // dispatch bypass from CDB1
        disp(5, 7, 0, 6, 0, 1, 0, 3); cdb(1, 6, 100); cyc(); idle(); #1;
        chk("e_valid", o_issue_valid, 1);
        chk("e_op1", o_issue_op1_value, 100);
        iss_rdy = 1'b1; cyc(); iss_rdy = 1'b0;

        // full station, middle issue with concurrent dispatch offered
        for (int i = 0; i < 4; i++) begin
            disp(6, 5'(i + 1), 0, 5'(20 + i), 0, 1, 0, 64'(i)); cyc();
        end
        idle(); #1;
        chk("d_full_ready", o_dispatch_ready, 0);
        chk("d_full_count", o_count, 4);
        chk("d_full_busy", o_debug_busy, 4'hF);
        cdb(0, 21, 77); cyc(); idle();
        disp(7, 5, 1, 0, 1, 1, 0, 2); iss_rdy = 1'b1; #1;
        chk("d_issue_dst", o_issue_dst_tag, 2);
        chk("d_issue_op1", o_issue_op1_value, 77);
        chk("d_ready_low", o_dispatch_ready, 0);
        cyc(); idle(); iss_rdy = 1'b0; #1;
        chk("d_count3", o_count, 3);
        chk("d_ready_back", o_dispatch_ready, 1);
        chk("d_busy7", o_debug_busy, 4'h7);

        // flush beats dispatch and issue
        cdb(0, 20, 1); cyc(); idle(); #1;
        chk("f_pre_valid", o_issue_valid, 1);
        chk("f_pre_dst", o_issue_dst_tag, 1);
        flush = 1'b1; disp(8, 9, 1, 0, 1, 1, 0, 1); iss_rdy = 1'b1; #1;
        chk("f_valid", o_issue_valid, 0);
        chk("f_payload", o_issue_op1_value, 0);
        cyc(); idle(); iss_rdy = 1'b0; #1;
        chk("f_count", o_count, 0);
        chk("f_busy", o_debug_busy, 0);

        // asynchronous reset mid-cycle
        disp(9, 13, 1, 0, 4, 1, 0, 6); cyc();
        disp(9, 14, 1, 0, 8, 1, 0, 9); cyc(); idle(); #1;
        chk("r_pre_count", o_count, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("r_count", o_count, 0);
        chk("r_valid", o_issue_valid, 0);
        chk("r_ready", o_dispatch_ready, 1);
        chk("r_busy", o_debug_busy, 0);
        chk("r_payload", o_issue_op1_value, 0);
        cyc(); rst_n = 1'b1;
        disp(10, 15, 1, 0, 3, 1, 0, 4); cyc(); idle(); #1;
        chk("r_after_valid", o_issue_valid, 1);
        chk("r_after_dst", o_issue_dst_tag, 15);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
